hex_display_driver: RTL and testbench

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_driver.sv | 102 ++++++++++
 tb/tb_hex_display_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Registered hex 7-segment driver: lamp test, blanking, leading-zero suppression and
// an optional blink feature compiled in only when HEX_DISPLAY_DRIVER_BLINK_EN is defined.
module hex_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_HALF = 25000000,
  parameter int LZS        = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lamp_test,
  output logic [7*NUM_DIGITS-1:0] display,
  output logic                    blink_phase
);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [7*NUM_DIGITS-1:0] display_d;
  logic [NUM_DIGITS-1:0]   blink_dark;
  logic                    run_zero;

  // Active-low segment patterns, bit 0 = segment a
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0011000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= '0;
    else if (load) value_q <= value;
  end

`ifdef HEX_DISPLAY_DRIVER_BLINK_EN
  localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] blink_cnt;
  logic          phase_q;

  // Free-running half-period counter; nothing but reset ever restarts it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_phase = phase_q;
  assign blink_dark  = phase_q ? blink_mask : '0;
`else
  logic unused_blink;

  assign unused_blink = ^blink_mask;
  assign blink_phase  = 1'b0;
  assign blink_dark   = '0;
`endif

  // Walk from the top digit down so run_zero means "this and all higher nibbles are 0"
  always_comb begin
    display_d = '1;
    run_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (value_q[4*i +: 4] == 4'h0);
      if (lamp_test)
        display_d[7*i +: 7] = 7'b0000000;
      else if (blank_mask[i] || blink_dark[i])
        display_d[7*i +: 7] = 7'b1111111;
      else if ((LZS != 0) && (i != 0) && run_zero)
        display_d[7*i +: 7] = 7'b1111111;
      else
        display_d[7*i +: 7] = decode(value_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) display <= '1;
    else display <= display_d;
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver (4 digits, blink half-period 4, LZS on);
// expectations adapt to whether HEX_DISPLAY_DRIVER_BLINK_EN is defined.
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int BH = 4;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] DARK = 7'b1111111;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    blink_mask = '0;
  logic          lamp_test = 1'b0;
  logic [27:0]   display;
  logic          blink_phase;

  int checks = 0;
  int errors = 0;

  logic [15:0] mValue = '0;
  int          mCnt = 0;
  logic        mPhase = 1'b0;
  logic [27:0] mDisp = '1;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_HALF(BH), .LZS(1)) dut (
    .clock(clock), .reset(reset), .load(load), .value(value),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lamp_test(lamp_test),
    .display(display), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  // Expected segments from the display rules; suppression uses "value shifted down is zero"
  function automatic logic [27:0] expectDisplay(input logic [15:0] v, input logic [3:0] blank,
                                                input logic [3:0] blinkm, input logic lamp,
                                                input logic phase);
    logic [27:0] r;
    r = '1;
    for (int d = 0; d < ND; d++) begin
      if (lamp) r[7*d +: 7] = 7'b0000000;
      else if (blank[d]) r[7*d +: 7] = DARK;
      else if (blinkm[d] && phase) r[7*d +: 7] = DARK;
      else if (d > 0 && (v >> (4*d)) == 16'd0) r[7*d +: 7] = DARK;
      else r[7*d +: 7] = SEG_TABLE[(v >> (4*d)) & 16'hF];
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mValue = '0;
      mCnt   = 0;
      mPhase = 1'b0;
      mDisp  = '1;
    end else begin
      mDisp = expectDisplay(mValue, blank_mask, blink_mask, lamp_test, mPhase);
      if (load) mValue = value;
`ifdef HEX_DISPLAY_DRIVER_BLINK_EN
      mCnt = (mCnt + 1) % BH;
      if (mCnt == 0) mPhase = ~mPhase;
`endif
    end
  end

  always @(negedge clock) begin
    checks++;
    if (display !== mDisp) begin
      errors++;
      $display("[TB] FAIL model_display t=%0t got %h expected %h", $time, display, mDisp);
    end
    checks++;
    if (blink_phase !== mPhase) begin
      errors++;
      $display("[TB] FAIL model_phase t=%0t got %b expected %b", $time, blink_phase, mPhase);
    end
  end

  task automatic checkOutput(input string name, input logic [27:0] actual, input logic [27:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] bl,
                               input logic [3:0] bk, input logic lt);
    @(negedge clock);
    load = ld;
    value = v;
    blank_mask = bl;
    blink_mask = bk;
    lamp_test = lt;
  endtask

  initial begin
    logic expPhase;
    logic [6:0] expDigit;

    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_display", display, '1);
    checkOutput("reset_phase", {27'd0, blink_phase}, 28'd0);

    // Release reset with a load of 7 pending and digit 0 blinking
    value = 16'h0007;
    load = 1'b1;
    blink_mask = 4'b0001;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checkOutput("post_reset_zero", display, {DARK, DARK, DARK, 7'b1000000});
        load = 1'b0;
      end
`ifdef HEX_DISPLAY_DRIVER_BLINK_EN
      expPhase = ((k / 4) % 2) == 1;
      expDigit = (k >= 2 && ((k - 1) / 4) % 2 == 1) ? DARK : 7'b1111000;
`else
      expPhase = 1'b0;
      expDigit = 7'b1111000;
`endif
      checkOutput("blink_phase_seq", {27'd0, blink_phase}, {27'd0, expPhase});
      if (k >= 2) checkOutput("blink_digit0_seq", {21'd0, display[6:0]}, {21'd0, expDigit});
    end

    applyStimulus(1'b1, 16'h00A5, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h00A5, 4'b0000, 4'b0000, 1'b0);
    checkOutput("a5_edge_n", display, {DARK, DARK, DARK, 7'b1111000});
    @(negedge clock);
    checkOutput("a5_edge_n1", display, {DARK, DARK, 7'b0001000, 7'b0010010});

    applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("zero_value", display, {DARK, DARK, DARK, 7'b1000000});

    applyStimulus(1'b1, 16'h1000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h1000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    checkOutput("value_1000", display, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000});

    applyStimulus(1'b0, 16'h1000, 4'b1111, 4'b0000, 1'b1);
    @(negedge clock);
    checkOutput("lamp_over_blank", display, 28'd0);
    lamp_test = 1'b0;
    @(negedge clock);
    checkOutput("blank_all", display, '1);

    // Steady 1234 with every digit blink-enabled, then reset between edges
    applyStimulus(1'b1, 16'h1234, 4'b0000, 4'b1111, 1'b0);
    applyStimulus(1'b0, 16'h1234, 4'b0000, 4'b1111, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
`ifndef HEX_DISPLAY_DRIVER_BLINK_EN
      checkOutput("noblink_steady", display, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
      checkOutput("noblink_phase", {27'd0, blink_phase}, 28'd0);
`endif
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_display", display, '1);
    checkOutput("async_reset_phase", {27'd0, blink_phase}, 28'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int c = 0; c < 400; c++) begin
      logic [15:0] v;
      v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      applyStimulus($urandom_range(0, 2) == 0, v,
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                    4'($urandom), $urandom_range(0, 15) == 0);
      if (c % 97 == 50) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
